// File: rtl/fl_pkg.sv
// Shared FrameLink types for the store-and-forward FIFO: stored word layout,
// forwarding state and a constant-safe ceil(log2) helper.
package fl_pkg;

    localparam int FL_DWIDTH    = 32;
    localparam int FL_DREMWIDTH = 2;

    // One buffered FrameLink word; delimiters kept active-low as on the wire.
    typedef struct packed {
        logic [FL_DWIDTH-1:0]    data;
        logic [FL_DREMWIDTH-1:0] drem;
        logic                    sof_n;
        logic                    eof_n;
        logic                    sop_n;
        logic                    eop_n;
    } fl_word_t;

    typedef enum logic {
        STORE = 1'b0,
        CUT   = 1'b1
    } fl_sf_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fl_sf_mem.sv
// Simple dual-port word store: synchronous write, asynchronous read so the
// FIFO head is visible in the same cycle (first-word fall-through).
module fl_sf_mem #(
    parameter int WIDTH  = 38,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fl_sf_fifo.sv
// Store-and-forward FrameLink FIFO with cut-through fallback for oversize frames.
// Optional status counter ports are enabled by defining FL_SF_FIFO_STATUS_EN.
//
//   state | meaning
//   STORE | release words only once a complete frame (EOF) is buffered
//   CUT   | oversize frame filled the FIFO; stream words until its EOF is read
module fl_sf_fifo
    import fl_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int DREMWIDTH = 2,
    parameter int DEPTH     = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [DWIDTH-1:0]    RX_DATA,
    input  logic [DREMWIDTH-1:0] RX_DREM,
    input  logic                 RX_SOF_N,
    input  logic                 RX_EOF_N,
    input  logic                 RX_SOP_N,
    input  logic                 RX_EOP_N,
    input  logic                 RX_SRC_RDY_N,
    output logic                 RX_DST_RDY_N,
    output logic [DWIDTH-1:0]    TX_DATA,
    output logic [DREMWIDTH-1:0] TX_DREM,
    output logic                 TX_SOF_N,
    output logic                 TX_EOF_N,
    output logic                 TX_SOP_N,
    output logic                 TX_EOP_N,
    output logic                 TX_SRC_RDY_N,
    input  logic                 TX_DST_RDY_N
`ifdef FL_SF_FIFO_STATUS_EN
    ,
    output logic [clog2(DEPTH+1)-1:0] STATUS_WORDS,
    output logic [clog2(DEPTH+1)-1:0] STATUS_FRAMES
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [DWIDTH-1:0]    data;
        logic [DREMWIDTH-1:0] drem;
        logic                 sof_n;
        logic                 eof_n;
        logic                 sop_n;
        logic                 eop_n;
    } word_t;

    localparam int WW = $bits(word_t);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_words;
    logic [CW-1:0] r_frames;
    fl_sf_state_t  r_state;

    word_t w_wr_word;
    word_t w_rd_word;
    logic  w_full;
    logic  w_rx_dst_rdy;
    logic  w_tx_avail;
    logic  w_tx_src_rdy;
    logic  w_wr;
    logic  w_rd;
    logic  w_wr_eof;
    logic  w_rd_eof;

    assign w_wr_word = {RX_DATA, RX_DREM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N};

    fl_sf_mem #(
        .WIDTH  (WW),
        .DEPTH  (DEPTH),
        .AWIDTH (AW)
    ) u_mem (
        .CLK     (CLK),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_word),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_word)
    );

    // Full blocks writes even when a read frees a slot in the same cycle.
    assign w_full       = (r_words == FULL_CNT);
    assign w_rx_dst_rdy = ~w_full & RESET_N;
    assign w_tx_avail   = (r_state == STORE) ? (r_frames != '0) : (r_words != '0);
    assign w_tx_src_rdy = w_tx_avail & RESET_N;

    assign w_wr     = ~RX_SRC_RDY_N & w_rx_dst_rdy;
    assign w_rd     = w_tx_src_rdy & ~TX_DST_RDY_N;
    assign w_wr_eof = w_wr & ~RX_EOF_N;
    assign w_rd_eof = w_rd & ~w_rd_word.eof_n;

    assign RX_DST_RDY_N = ~w_rx_dst_rdy;
    assign TX_SRC_RDY_N = ~w_tx_src_rdy;

    always_comb begin
        TX_DATA  = '0;
        TX_DREM  = '0;
        TX_SOF_N = 1'b1;
        TX_EOF_N = 1'b1;
        TX_SOP_N = 1'b1;
        TX_EOP_N = 1'b1;
        if (w_tx_src_rdy) begin
            TX_DATA  = w_rd_word.data;
            TX_DREM  = w_rd_word.drem;
            TX_SOF_N = w_rd_word.sof_n;
            TX_EOF_N = w_rd_word.eof_n;
            TX_SOP_N = w_rd_word.sop_n;
            TX_EOP_N = w_rd_word.eop_n;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_words  <= '0;
            r_frames <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_words <= r_words + CW'(1);
                2'b01:   r_words <= r_words - CW'(1);
                default: ;
            endcase
            case ({w_wr_eof, w_rd_eof})
                2'b10:   r_frames <= r_frames + CW'(1);
                2'b01:   r_frames <= r_frames - CW'(1);
                default: ;
            endcase
        end
    end

    // A full FIFO with no complete frame can only drain by cutting through.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= STORE;
        end else begin
            case (r_state)
                STORE: begin
                    if (w_full && (r_frames == '0)) begin
                        r_state <= CUT;
                    end
                end
                CUT: begin
                    if (w_rd_eof) begin
                        r_state <= STORE;
                    end
                end
                default: r_state <= STORE;
            endcase
        end
    end

`ifdef FL_SF_FIFO_STATUS_EN
    assign STATUS_WORDS  = r_words;
    assign STATUS_FRAMES = r_frames;
`endif

endmodule

// File: tb/tb_fl_sf_fifo.sv
// Directed bench for fl_sf_fifo: hand-built frames, an expected-word queue
// checked at every read transfer, and counter/state checks at key points.
module tb_fl_sf_fifo;
    import fl_pkg::*;

    localparam int DW    = 32;
    localparam int RW    = 2;
    localparam int DEPTH = 16;
    localparam logic [37:0] IDLE_TX = {32'h0, 2'b00, 4'hF};

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [DW-1:0] RX_DATA;
    logic [RW-1:0] RX_DREM;
    logic          RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N;
    logic          RX_SRC_RDY_N;
    logic          RX_DST_RDY_N;
    logic [DW-1:0] TX_DATA;
    logic [RW-1:0] TX_DREM;
    logic          TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N;
    logic          TX_SRC_RDY_N;
    logic          TX_DST_RDY_N;
    logic [37:0]   w_tx;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rd  = 0;
    int          rd0;
    logic [37:0] q_exp[$];

    always #5 CLK = ~CLK;

    fl_sf_fifo #(.DWIDTH(DW), .DREMWIDTH(RW), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .RX_DATA      (RX_DATA),
        .RX_DREM      (RX_DREM),
        .RX_SOF_N     (RX_SOF_N),
        .RX_EOF_N     (RX_EOF_N),
        .RX_SOP_N     (RX_SOP_N),
        .RX_EOP_N     (RX_EOP_N),
        .RX_SRC_RDY_N (RX_SRC_RDY_N),
        .RX_DST_RDY_N (RX_DST_RDY_N),
        .TX_DATA      (TX_DATA),
        .TX_DREM      (TX_DREM),
        .TX_SOF_N     (TX_SOF_N),
        .TX_EOF_N     (TX_EOF_N),
        .TX_SOP_N     (TX_SOP_N),
        .TX_EOP_N     (TX_EOP_N),
        .TX_SRC_RDY_N (TX_SRC_RDY_N),
        .TX_DST_RDY_N (TX_DST_RDY_N)
    );

    assign w_tx = {TX_DATA, TX_DREM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mkw(input logic [31:0] data, input logic [1:0] drem,
                                        input logic sof, input logic eof,
                                        input logic sop, input logic eop);
        return {data, drem, sof, eof, sop, eop};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one word and hold it until the FIFO accepts it (bounded).
    task automatic put(input logic [37:0] w);
        int n;
        n = 0;
        {RX_DATA, RX_DREM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N} = w;
        RX_SRC_RDY_N = 1'b0;
        while (RX_DST_RDY_N && n < 64) begin
            tick();
            n++;
        end
        if (RX_DST_RDY_N) begin
            chk("put_stall", 64'(RX_DST_RDY_N), 64'd0);
        end else begin
            q_exp.push_back(w);
            tick();
        end
        RX_SRC_RDY_N = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        TX_DST_RDY_N = 1'b0;
        while (dut.r_words != '0 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 64'(dut.r_words), 64'd0);
    endtask

    // Every read transfer must return the next expected word.
    always @(negedge CLK) begin
        if (RESET_N && !TX_SRC_RDY_N && !TX_DST_RDY_N) begin
            if (q_exp.size() == 0) begin
                chk("unexp_read", 64'(q_exp.size()), 64'd1);
            end else begin
                chk("rd_word", 64'(w_tx), 64'(q_exp.pop_front()));
                n_rd++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N      = 1'b0;
        RX_SRC_RDY_N = 1'b1;
        {RX_DATA, RX_DREM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N} = {32'h0, 2'b00, 4'hF};
        TX_DST_RDY_N = 1'b1;
        tick();
        tick();
        chk("rst_rx_dst", 64'(RX_DST_RDY_N), 64'd1);
        chk("rst_tx_src", 64'(TX_SRC_RDY_N), 64'd1);
        chk("rst_tx_idle", 64'(w_tx), 64'(IDLE_TX));
        RESET_N = 1'b1;
        #1;
        chk("rel_words", 64'(dut.r_words), 64'd0);
        chk("rel_rx_dst", 64'(RX_DST_RDY_N), 64'd0);
        chk("rel_state", 64'(dut.r_state), 64'(STORE));

        // 3-word frame, released only after EOF
        TX_DST_RDY_N = 1'b0;
        put(mkw(32'hA000_0001, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1));
        chk("t1_hold0", 64'(TX_SRC_RDY_N), 64'd1);
        put(mkw(32'hA000_0002, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1));
        chk("t1_hold1", 64'(TX_SRC_RDY_N), 64'd1);
        put(mkw(32'hA000_0003, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0));
        chk("t1_rdy", 64'(TX_SRC_RDY_N), 64'd0);
        chk("t1_frames1", 64'(dut.r_frames), 64'd1);
        rd0 = n_rd;
        tick();
        tick();
        tick();
        chk("t1_reads", 64'(n_rd - rd0), 64'd3);
        chk("t1_frames0", 64'(dut.r_frames), 64'd0);
        chk("t1_words0", 64'(dut.r_words), 64'd0);
        chk("t1_idle", 64'(w_tx), 64'(IDLE_TX));

        // 1-word frame
        put(mkw(32'h5555_AAAA, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("t2_rdy", 64'(TX_SRC_RDY_N), 64'd0);
        chk("t2_sof", 64'(TX_SOF_N), 64'd0);
        chk("t2_eof", 64'(TX_EOF_N), 64'd0);
        tick();
        chk("t2_words0", 64'(dut.r_words), 64'd0);

        // Fill with sixteen 1-word frames, then hold a 17th
        TX_DST_RDY_N = 1'b1;
        for (int i = 0; i < 16; i++) begin
            put(mkw(32'(32'h100 + i), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        chk("t3_full", 64'(RX_DST_RDY_N), 64'd1);
        chk("t3_words", 64'(dut.r_words), 64'd16);
        chk("t3_frames", 64'(dut.r_frames), 64'd16);
        chk("t3_state", 64'(dut.r_state), 64'(STORE));
        {RX_DATA, RX_DREM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N} =
            mkw(32'h200, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        RX_SRC_RDY_N = 1'b0;
        q_exp.push_back(mkw(32'h200, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        chk("t3_held", 64'(dut.r_words), 64'd16);
        TX_DST_RDY_N = 1'b0;
        tick();
        TX_DST_RDY_N = 1'b1;
        chk("t3_rd_nowr", 64'(dut.r_words), 64'd15);
        chk("t3_rx_rdy", 64'(RX_DST_RDY_N), 64'd0);
        tick();
        RX_SRC_RDY_N = 1'b1;
        chk("t3_refill", 64'(dut.r_words), 64'd16);
        drain("t3_drain");
        chk("t3_frames0", 64'(dut.r_frames), 64'd0);

        // 20-word oversize frame forces cut-through
        TX_DST_RDY_N = 1'b0;
        rd0 = n_rd;
        for (int i = 0; i < 16; i++) begin
            put(mkw(32'(32'h4000_0000 + i), 2'd0, (i == 0) ? 1'b0 : 1'b1, 1'b1,
                    (i == 0) ? 1'b0 : 1'b1, 1'b1));
        end
        chk("t4_words16", 64'(dut.r_words), 64'd16);
        chk("t4_pre_state", 64'(dut.r_state), 64'(STORE));
        tick();
        chk("t4_cut_state", 64'(dut.r_state), 64'(CUT));
        chk("t4_cut_words", 64'(dut.r_words), 64'd16);
        for (int i = 16; i < 20; i++) begin
            put(mkw(32'(32'h4000_0000 + i), (i == 19) ? 2'd1 : 2'd0, 1'b1,
                    (i == 19) ? 1'b0 : 1'b1, 1'b1, (i == 19) ? 1'b0 : 1'b1));
        end
        drain("t4_drain");
        chk("t4_reads", 64'(n_rd - rd0), 64'd20);
        chk("t4_state", 64'(dut.r_state), 64'(STORE));
        chk("t4_frames0", 64'(dut.r_frames), 64'd0);

        // Simultaneous EOF write and EOF read
        TX_DST_RDY_N = 1'b1;
        put(mkw(32'h7000_0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("t5_pre_frames", 64'(dut.r_frames), 64'd1);
        TX_DST_RDY_N = 1'b0;
        put(mkw(32'h7000_0002, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("t5_frames", 64'(dut.r_frames), 64'd1);
        chk("t5_words", 64'(dut.r_words), 64'd1);
        drain("t5_drain");
        chk("t5_frames0", 64'(dut.r_frames), 64'd0);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) begin
            put(mkw(32'(32'h9000_0000 + i), 2'd0, (i == 0) ? 1'b0 : 1'b1, 1'b1,
                    (i == 0) ? 1'b0 : 1'b1, 1'b1));
        end
        chk("t6_words5", 64'(dut.r_words), 64'd5);
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_rx", 64'(RX_DST_RDY_N), 64'd1);
        chk("t6_rst_tx", 64'(TX_SRC_RDY_N), 64'd1);
        chk("t6_rst_words", 64'(dut.r_words), 64'd0);
        q_exp.delete();
        tick();
        RESET_N = 1'b1;
        #1;
        chk("t6_rel_words", 64'(dut.r_words), 64'd0);
        chk("t6_rel_rx", 64'(RX_DST_RDY_N), 64'd0);
        rd0 = n_rd;
        put(mkw(32'hB000_0001, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        put(mkw(32'hB000_0002, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0));
        drain("t6_drain");
        chk("t6_reads", 64'(n_rd - rd0), 64'd2);
        chk("t6_frames0", 64'(dut.r_frames), 64'd0);
        chk("q_empty", 64'(q_exp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
